// File: rtl/demux_pkg.sv
// Shared definitions for the serial-to-parallel demux capture block:
// FSM state encoding and default word/index widths.
package demux_pkg;

    localparam int DEF_WIDTH = 32;
    localparam int DEF_SEL_W = 5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SCAN = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/demux_1to32_capture_if.sv
// Bus bundle between an upstream bit source (master) and the demux capture
// block (slave): serial bit, routing controls and the captured word/status.
interface demux_1to32_capture_if #(
    parameter int WIDTH = 32,
    parameter int SEL_W = 5
);
    logic             in;
    logic [SEL_W-1:0] sel;
    logic             wr;
    logic             scan_start;
    logic             in_valid;
    logic             clear;
    logic [WIDTH-1:0] q;
    logic             busy;
    logic             done;
    logic [SEL_W-1:0] idx;

    modport master (
        output in, sel, wr, scan_start, in_valid, clear,
        input  q, busy, done, idx
    );

    modport slave (
        input  in, sel, wr, scan_start, in_valid, clear,
        output q, busy, done, idx
    );
endinterface

// File: rtl/demux_index_cnt.sv
// Scan index counter: synchronous clear has priority over enable, wraps
// naturally at 2**SEL_W, and flags the terminal (last) index.
module demux_index_cnt #(
    parameter int SEL_W = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             en,
    output logic [SEL_W-1:0] count,
    output logic             tc
);

    // Terminal count: the index currently addressed is the last bit of the word.
    assign tc = (count == {SEL_W{1'b1}});

    // Index register: clear wins, otherwise step by one on enable.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (en) begin
            count <= count + SEL_W'(1);
        end
    end

endmodule

// File: rtl/demux_1to32_capture.sv
// 1-to-WIDTH sequential demux: steers a serial bit into one bit of a
// registered word, either by explicit select (single writes) or by an
// auto-scan that rebuilds a whole word LSB-first from a serial stream.
module demux_1to32_capture
    import demux_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int SEL_W = DEF_SEL_W
) (
    input  logic                  clk,
    input  logic                  rst,
    demux_1to32_capture_if.slave  bus
);

    state_t           state;
    logic             busy_r;
    logic             done_r;
    logic [WIDTH-1:0] q_r;
    logic [SEL_W-1:0] idx_cnt;
    logic             idx_tc;
    logic             idx_clear;
    logic             scan_take;
    logic             single_wr;

    // A scan bit is consumed only in SCAN with a qualified bit; clear overrides.
    assign scan_take = (state == SCAN) && bus.in_valid && !bus.clear;
    // Single writes are honoured only while idle; SCAN and DONE ignore wr.
    assign single_wr = (state == IDLE) && bus.wr && !bus.clear;
    // Index restarts on clear/abort and whenever a new scan is accepted.
    assign idx_clear = bus.clear || ((state == IDLE) && bus.scan_start);

    demux_index_cnt #(
        .SEL_W (SEL_W)
    ) u_idx (
        .clk   (clk),
        .rst   (rst),
        .clear (idx_clear),
        .en    (scan_take),
        .count (idx_cnt),
        .tc    (idx_tc)
    );

    // Control FSM with registered busy/done decodes of the next state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else if (bus.clear) begin
            // Abort: back to idle without a done pulse.
            state  <= IDLE;
            busy_r <= 1'b0;
            done_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done_r <= 1'b0;
                    if (bus.scan_start) begin
                        state  <= SCAN;
                        busy_r <= 1'b1;
                    end else begin
                        busy_r <= 1'b0;
                    end
                end
                SCAN: begin
                    if (bus.in_valid && idx_tc) begin
                        state  <= DONE;
                        busy_r <= 1'b0;
                        done_r <= 1'b1;
                    end
                end
                DONE: begin
                    // Single-cycle completion flag, then always idle.
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
                default: begin
                    // Unused encoding recovers to idle.
                    state  <= IDLE;
                    busy_r <= 1'b0;
                    done_r <= 1'b0;
                end
            endcase
        end
    end

    // Word register: clear > scan bit > single write; untouched bits hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r <= '0;
        end else if (bus.clear) begin
            q_r <= '0;
        end else if (scan_take) begin
            q_r[idx_cnt] <= bus.in;
        end else if (single_wr) begin
            q_r[bus.sel] <= bus.in;
        end
    end

    assign bus.q    = q_r;
    assign bus.busy = busy_r;
    assign bus.done = done_r;
    assign bus.idx  = idx_cnt;

endmodule

// File: tb/tb_demux_1to32_capture.sv
// Self-checking bench for demux_1to32_capture: directed scenarios plus a
// randomized phase, all compared every cycle against a behavioural model.
module tb_demux_1to32_capture;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;
    int   busy_cnt;
    int   done_cnt;

    // Behavioural model: the captured word, whether a scan is running, how
    // many scan bits have been taken so far, and whether the done cycle is due.
    logic [31:0] m_q;
    bit          m_scan;
    int          m_pos;
    bit          m_done;

    demux_1to32_capture_if #(.WIDTH(32), .SEL_W(5)) bus ();

    demux_1to32_capture #(.WIDTH(32), .SEL_W(5)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
        end
    endtask

    task automatic idle_inputs();
        bus.in         = 1'b0;
        bus.sel        = '0;
        bus.wr         = 1'b0;
        bus.scan_start = 1'b0;
        bus.in_valid   = 1'b0;
        bus.clear      = 1'b0;
    endtask

    task automatic model_reset();
        m_q    = '0;
        m_scan = 1'b0;
        m_pos  = 0;
        m_done = 1'b0;
    endtask

    // One clock: predict from current inputs, clock, then compare all outputs.
    task automatic cycle();
        logic [31:0] nq;
        int          npos;
        bit          nscan;
        bit          ndone;
        nq    = m_q;
        npos  = m_pos;
        nscan = m_scan;
        ndone = 1'b0;
        if (bus.clear) begin
            nq    = '0;
            npos  = 0;
            nscan = 1'b0;
        end else if (m_done) begin
            nscan = 1'b0;
        end else if (m_scan) begin
            if (bus.in_valid) begin
                nq[m_pos] = bus.in;
                npos = m_pos + 1;
                if (npos == 32) begin
                    npos  = 0;
                    nscan = 1'b0;
                    ndone = 1'b1;
                end
            end
        end else begin
            if (bus.wr) nq[bus.sel] = bus.in;
            if (bus.scan_start) begin
                nscan = 1'b1;
                npos  = 0;
            end
        end
        @(posedge clk);
        #1;
        m_q    = nq;
        m_pos  = npos;
        m_scan = nscan;
        m_done = ndone;
        check("q",    bus.q,           m_q);
        check("idx",  32'(bus.idx),    32'(m_pos));
        check("busy", 32'(bus.busy),   32'(m_scan));
        check("done", 32'(bus.done),   32'(m_done));
        if (bus.busy) busy_cnt++;
        if (bus.done) done_cnt++;
    endtask

    task automatic single_write(input logic [4:0] s, input logic b);
        idle_inputs();
        bus.wr  = 1'b1;
        bus.sel = s;
        bus.in  = b;
        cycle();
        idle_inputs();
    endtask

    // Full scan of one word, optional stall at a bit index, optional pokes
    // (wr to bit 5 plus repeated scan_start) while the scan is running.
    task automatic run_scan(input logic [31:0] word, input int stall_at,
                            input int stall_len, input bit poke);
        int b;
        int st;
        b = 0;
        st = 0;
        busy_cnt = 0;
        done_cnt = 0;
        idle_inputs();
        bus.scan_start = 1'b1;
        cycle();
        for (int t = 0; t < 32 + stall_len + 3; t++) begin
            idle_inputs();
            if (b == stall_at && st < stall_len) begin
                st++;
                check("stall_idx", 32'(bus.idx), 32'(stall_at));
            end else if (b < 32) begin
                bus.in_valid = 1'b1;
                bus.in       = word[b];
                b++;
            end
            if (poke && bus.in_valid && bus.in && b < 32) begin
                bus.wr         = 1'b1;
                bus.sel        = 5'd5;
                bus.scan_start = 1'b1;
            end
            cycle();
        end
        idle_inputs();
        check("scan_q",           bus.q,            word);
        check("scan_busy_cycles", 32'(busy_cnt),    32'(32 + stall_len));
        check("scan_done_pulses", 32'(done_cnt),    32'd1);
        check("scan_idx_end",     32'(bus.idx),     32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] abort_word;
        n_cmp = 0;
        n_err = 0;
        busy_cnt = 0;
        done_cnt = 0;
        idle_inputs();
        model_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("rst_q",    bus.q,          32'd0);
        check("rst_idx",  32'(bus.idx),   32'd0);
        check("rst_busy", 32'(bus.busy),  32'd0);
        check("rst_done", 32'(bus.done),  32'd0);
        rst = 1'b0;
        cycle();

        // Async reset mid-cycle with a full word and a running scan.
        run_scan(32'hFFFF_FFFF, -1, 0, 1'b0);
        bus.scan_start = 1'b1;
        cycle();
        idle_inputs();
        repeat (3) cycle();
        check("pre_rst_q",    bus.q,         32'hFFFF_FFFF);
        check("pre_rst_busy", 32'(bus.busy), 32'd1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_q",    bus.q,         32'd0);
        check("async_rst_idx",  32'(bus.idx),  32'd0);
        check("async_rst_busy", 32'(bus.busy), 32'd0);
        check("async_rst_done", 32'(bus.done), 32'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst = 1'b0;
        cycle();

        // Single writes in idle.
        single_write(5'd0,  1'b1);
        single_write(5'd1,  1'b1);
        single_write(5'd17, 1'b1);
        single_write(5'd31, 1'b1);
        check("wr_pattern", bus.q, 32'h8002_0003);
        single_write(5'd1, 1'b0);
        check("wr_clear_bit", bus.q, 32'h8002_0001);

        // Full scan, stalled scan, ignore-while-busy.
        run_scan(32'hAAAA_AAAA, -1, 0, 1'b0);
        run_scan(32'hAAAA_AAAA, 10, 3, 1'b0);
        run_scan(32'h5555_5555, -1, 0, 1'b1);
        check("poke_bit5", 32'(bus.q[5]), 32'd0);

        // Abort at idx 20 with clear, then a clean scan.
        abort_word = 32'hDEAD_BEEF;
        busy_cnt = 0;
        done_cnt = 0;
        idle_inputs();
        bus.scan_start = 1'b1;
        cycle();
        for (int b = 0; b < 20; b++) begin
            idle_inputs();
            bus.in_valid = 1'b1;
            bus.in       = abort_word[b];
            cycle();
        end
        check("abort_at_idx", 32'(bus.idx), 32'd20);
        idle_inputs();
        bus.clear    = 1'b1;
        bus.in_valid = 1'b1;
        bus.in       = 1'b1;
        cycle();
        idle_inputs();
        check("abort_q",    bus.q,         32'd0);
        check("abort_busy", 32'(bus.busy), 32'd0);
        repeat (3) cycle();
        check("abort_no_done", 32'(done_cnt), 32'd0);
        run_scan(32'h1234_5678, -1, 0, 1'b0);

        // Randomized traffic against the model.
        for (int t = 0; t < 3000; t++) begin
            bus.in         = 1'($urandom_range(0, 1));
            bus.sel        = 5'($urandom_range(0, 31));
            bus.wr         = ($urandom_range(0, 2) == 0);
            bus.scan_start = ($urandom_range(0, 9) == 0);
            bus.in_valid   = ($urandom_range(0, 3) != 0);
            bus.clear      = ($urandom_range(0, 79) == 0);
            cycle();
        end
        idle_inputs();
        cycle();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/demux_1to32_capture.md
Name: demux_1to32_capture

Overview:
- Sequential 1-to-WIDTH demultiplexer: the receiving end of the existing 32:1 mux path.
- Routes a single serial bit `in` into the bit of a registered WIDTH-bit word `q` chosen by `sel`, driven by individual writes.
- Also provides an auto-scan mode: an internal index walks 0..WIDTH-1 and rebuilds a full word from a serial stream.
- Sits downstream of mux_32to1-style selectors to reassemble a word that was sent out one bit at a time.

Parameters:
- WIDTH, 32, number of output bits / demux destinations; power of two, at least 2.
- SEL_W, 5, select/index width, equal to log2(WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst  input  1  asynchronous, active-high reset.
- in  input  1  serial data bit to be routed.
- sel  input  SEL_W  destination bit index for single writes.
- wr  input  1  single-write strobe: q[sel] <= in.
- scan_start  input  1  starts an auto-scan capture of WIDTH bits.
- in_valid  input  1  during scan, qualifies `in` as the next bit.
- clear  input  1  synchronous clear of q; aborts any scan.
- q  output  WIDTH  captured word (registered).
- busy  output  1  high while state is SCAN.
- done  output  1  one-cycle pulse when a scan completes.
- idx  output  SEL_W  current scan index (registered).

Behaviour:
- Reset (async, rst=1): q=0, idx=0, busy=0, done=0, state=IDLE; takes effect immediately, independent of clk.
- States are IDLE, SCAN and DONE. busy is decoded from state==SCAN; done is decoded from state==DONE. Both are glitch-free registered decodes.
- Priority each cycle: clear > scan logic > wr.
- clear=1, any state: q<=0, idx<=0, next state IDLE. A scan in progress is aborted and done is NOT pulsed.
- IDLE, wr=1: q[sel]<=in on the clock edge. Other bits hold. Latency is 1 cycle (q is visible the cycle after the edge).
- IDLE, scan_start=1: next state SCAN, idx<=0. If wr=1 in the same cycle, the write also happens.
- SCAN, in_valid=1: q[idx]<=in; idx<=idx+1.
  - If idx==WIDTH-1: idx wraps to 0 and the next state is DONE.
- SCAN, in_valid=0: hold; no q or idx change.
- In SCAN, wr and scan_start are ignored (no restart, no write).
- Bits of q not yet overwritten during a scan keep their previous values. The scan does not pre-clear q.
- DONE: lasts exactly 1 cycle with done=1, then unconditionally returns to IDLE. wr and scan_start are ignored during DONE.
- A full scan with in_valid held high takes WIDTH cycles in SCAN plus 1 DONE cycle. The earliest restart is the cycle after DONE.
- Scan bit order: the first valid bit lands in q[0] and the last in q[WIDTH-1], which is LSB-first and mirrors the mux select order 0..31.
- sel is always in range because it is SEL_W bits wide. No x is ever driven onto q.

Decomposition:
- Shared package demux_pkg:
  - state encoding constants: IDLE=2'd0, SCAN=2'd1, DONE=2'd2.
  - default WIDTH/SEL_W constants.
- Unreachable encoding 2'd3 recovers to IDLE.
- One natural sub-module, demux_index_cnt: an SEL_W-bit counter with clear, enable and terminal-count output, used for idx.
- The q write decode stays in the top module.

Test Plan:
- Reset values: assert rst mid-cycle with q=32'hFFFF_FFFF, busy=1 → q=0, idx=0, busy=0, done=0 immediately, without waiting for a clk edge.
- Single writes (IDLE): in=1 with sel=5'd0, then 5'd1, then 5'd17, then 5'd31, each for one wr cycle → q=32'h8002_0003; a following wr with sel=5'd1, in=0 → q=32'h8002_0001.
- Full scan: scan_start, then 32 valid bits forming 32'hAAAA_AAAA LSB-first with in_valid held high → q=32'hAAAA_AAAA, busy high for exactly 32 cycles, done pulses for 1 cycle, idx returns to 0.
- Stalled scan: same stream as the full scan, with in_valid dropped for 3 cycles at idx=10 → idx holds at 10, final q=32'hAAAA_AAAA, busy high for 35 cycles.
- Ignore-while-busy: wr with sel=5'd5, in=1, plus a repeated scan_start during SCAN → no effect on q; the scan continues; a single done pulse.
- Abort: clear at idx=20 during a scan → q=0, state IDLE next cycle, no done pulse; a new scan_start is then accepted and completes normally with 32'h1234_5678.
